// File: rtl/serial_link_vc_credit_ctrl.sv
// Per-VC credit flow control for the serial link: sender credit counters and receiver credit returns.
// Latency: every output is decoded from registers, so an input is reflected one core_clk edge later.
// Backpressure: credits_avail_o gates the sender per VC; force_send_o asks for a credit-only flit.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   credits_avail_o          VC may send (credit counter non-zero)
//   send_i                   flit sent on VC this cycle
//   credits_in_valid_i/vc_i/credits_in_i   credits returned by the peer
//   consumed_i               local RX buffer slot freed per VC
//   credits_to_send_valid_o/vc_o/credits_to_send_o   return offered to the outgoing flit
//   credits_taken_i          outgoing flit carried the offered return
//   force_send_o             pending returns reached the threshold
//   err_o, clr_err_i         sticky protocol error per VC and its clear
// Optional feature: define SERIAL_LINK_CREDIT_ERR_EN to enable err_o; otherwise err_o is 0.
module serial_link_vc_credit_ctrl #(
  parameter int unsigned NumVc           = 2,
  parameter int unsigned NumCredits      = 8,
  parameter int unsigned ForceSendThresh = NumCredits - 2,
  parameter int unsigned CntW            = $clog2(NumCredits) + 1,
  parameter int unsigned VcW             = (NumVc > 1) ? $clog2(NumVc) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [NumVc-1:0] credits_avail_o,
  input  logic [NumVc-1:0] send_i,
  input  logic             credits_in_valid_i,
  input  logic [VcW-1:0]   credits_in_vc_i,
  input  logic [CntW-1:0]  credits_in_i,
  input  logic [NumVc-1:0] consumed_i,
  output logic             credits_to_send_valid_o,
  output logic [VcW-1:0]   credits_to_send_vc_o,
  output logic [CntW-1:0]  credits_to_send_o,
  input  logic             credits_taken_i,
  output logic             force_send_o,
  output logic [NumVc-1:0] err_o,
  input  logic             clr_err_i
);

  localparam logic [CntW:0]   MaxSum  = (CntW+1)'(NumCredits);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(NumCredits);
  localparam logic [CntW-1:0] ThrsCnt = CntW'(ForceSendThresh);

  logic [NumVc-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [NumVc-1:0][CntW-1:0] pend_q, pend_d;
  // One extra bit so overflow past NumCredits is visible before saturation.
  logic [NumVc-1:0][CntW:0]   cnt_sum, pend_sum;

  logic            any_pend, force_d;
  logic [VcW-1:0]  sel_vc;
  logic [CntW-1:0] sel_cnt;

  // Return selection: largest pending count wins; strict '>' keeps the lowest index on ties.
  always_comb begin
    sel_vc   = '0;
    sel_cnt  = pend_q[0];
    any_pend = 1'b0;
    force_d  = 1'b0;
    for (int v = 0; v < int'(NumVc); v++) begin
      if (pend_q[v] > sel_cnt) begin
        sel_cnt = pend_q[v];
        sel_vc  = VcW'(v);
      end
      any_pend = any_pend | (pend_q[v] != '0);
      force_d  = force_d | (pend_q[v] >= ThrsCnt);
    end
  end

  always_comb begin
    cnt_sum  = '0;
    cnt_d    = '0;
    pend_sum = '0;
    pend_d   = '0;
    for (int v = 0; v < int'(NumVc); v++) begin
      // Sender: a send with no credit is dropped rather than wrapping the counter.
      cnt_sum[v] = {1'b0, cnt_q[v]}
                 - (CntW+1)'(send_i[v] && (cnt_q[v] != '0))
                 + ((credits_in_valid_i && (credits_in_vc_i == VcW'(v)))
                    ? {1'b0, credits_in_i} : '0);
      cnt_d[v]   = (cnt_sum[v] > MaxSum) ? MaxCnt : cnt_sum[v][CntW-1:0];

      // Receiver: a take clears the whole offered count; a same-cycle consume survives it.
      pend_sum[v] = ((credits_taken_i && any_pend && (sel_vc == VcW'(v)))
                     ? '0 : {1'b0, pend_q[v]})
                  + (CntW+1)'(consumed_i[v]);
      pend_d[v]   = (pend_sum[v] > MaxSum) ? MaxCnt : pend_sum[v][CntW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int v = 0; v < int'(NumVc); v++) begin
        cnt_q[v]  <= MaxCnt;
        pend_q[v] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    for (int v = 0; v < int'(NumVc); v++) begin
      credits_avail_o[v] = (cnt_q[v] != '0);
    end
  end

  assign credits_to_send_valid_o = any_pend;
  assign credits_to_send_vc_o    = sel_vc;
  assign credits_to_send_o       = sel_cnt;
  assign force_send_o            = force_d;

`ifdef SERIAL_LINK_CREDIT_ERR_EN
  logic [NumVc-1:0] err_q, err_set;

  always_comb begin
    for (int v = 0; v < int'(NumVc); v++) begin
      err_set[v] = (send_i[v] && (cnt_q[v] == '0)) || (cnt_sum[v] > MaxSum);
    end
  end

  // A fresh error in the clear cycle is kept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= '0;
    end else begin
      err_q <= (clr_err_i ? '0 : err_q) | err_set;
    end
  end

  assign err_o = err_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err_i;
  assign err_o          = '0;
`endif

endmodule

// File: tb/tb_serial_link_vc_credit_ctrl.sv
// Bench for serial_link_vc_credit_ctrl: behavioural model plus directed literal checks.
// Latency: model state advances on each clock edge, outputs compared on the falling edge.
// Backpressure: stimulus honours nothing; the model reproduces ignore/saturate rules.
module tb_serial_link_vc_credit_ctrl;

`ifdef SERIAL_LINK_CREDIT_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  localparam int NV = 2;
  localparam int NC = 8;
  localparam int TH = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] avail;
  logic [1:0] send;
  logic       cin_vld;
  logic       cin_vc;
  logic [3:0] cin;
  logic [1:0] consumed;
  logic       ts_vld;
  logic       ts_vc;
  logic [3:0] ts_cnt;
  logic       taken;
  logic       force_s;
  logic [1:0] err;
  logic       clr_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: plain integers, not bit-accurate registers.
  int cnt_m [NV];
  int pend_m[NV];
  int err_m [NV];

  serial_link_vc_credit_ctrl #(.NumVc(2), .NumCredits(8), .ForceSendThresh(6)) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .credits_avail_o        (avail),
    .send_i                 (send),
    .credits_in_valid_i     (cin_vld),
    .credits_in_vc_i        (cin_vc),
    .credits_in_i           (cin),
    .consumed_i             (consumed),
    .credits_to_send_valid_o(ts_vld),
    .credits_to_send_vc_o   (ts_vc),
    .credits_to_send_o      (ts_cnt),
    .credits_taken_i        (taken),
    .force_send_o           (force_s),
    .err_o                  (err),
    .clr_err_i              (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_sel();
    int s = 0;
    for (int v = 1; v < NV; v++) if (pend_m[v] > pend_m[s]) s = v;
    return s;
  endfunction

  function automatic int model_any();
    int a = 0;
    for (int v = 0; v < NV; v++) if (pend_m[v] != 0) a = 1;
    return a;
  endfunction

  function automatic int model_force();
    int f = 0;
    for (int v = 0; v < NV; v++) if (pend_m[v] >= TH) f = 1;
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NV; v++) begin
        cnt_m[v] = NC; pend_m[v] = 0; err_m[v] = 0;
      end
    end else begin
      int sel, any, nx, e;
      sel = model_sel();
      any = model_any();
      for (int v = 0; v < NV; v++) begin
        e  = 0;
        nx = cnt_m[v];
        if (send[v]) begin
          if (cnt_m[v] == 0) e = 1; else nx = nx - 1;
        end
        if (cin_vld && cin_vc == v) nx = nx + cin;
        if (nx > NC) begin e = 1; nx = NC; end
        cnt_m[v] = nx;
        if (ERR_EN != 0) begin
          if (clr_err) err_m[v] = 0;
          if (e != 0) err_m[v] = 1;
        end
        if (taken && any != 0 && sel == v) pend_m[v] = 0;
        pend_m[v] = pend_m[v] + consumed[v];
        if (pend_m[v] > NC) pend_m[v] = NC;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int v = 0; v < NV; v++) begin
        chk($sformatf("avail%0d", v), avail[v], cnt_m[v] != 0);
        chk($sformatf("err%0d", v), err[v], err_m[v]);
      end
      chk("ts_vld", ts_vld, model_any());
      chk("force", force_s, model_force());
      if (model_any() != 0) begin
        chk("ts_vc", ts_vc, model_sel());
        chk("ts_cnt", ts_cnt, pend_m[model_sel()]);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle();
    send = '0; cin_vld = 0; cin_vc = 0; cin = '0;
    consumed = '0; taken = 0; clr_err = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_avail", avail, 3);
    chk("rst_vld", ts_vld, 0);
    chk("rst_force", force_s, 0);
    chk("rst_err", err, 0);
    rst_n = 1;

    // Drain VC0: 8 sends empty it, the 9th is ignored.
    send = 2'b01;
    tick(7);
    chk("drain7_avail", avail, 3);
    tick(1);
    chk("drain8_avail", avail, 2);
    tick(1);
    chk("drain9_avail", avail, 2);
    chk("drain9_err0", err[0], ERR_EN);
    send = '0;
    clr_err = 1;
    tick(1);
    clr_err = 0;
    chk("clr_err", err, 0);

    // cnt0: 0 -> 2, then send + return 3 -> 4.
    cin_vld = 1; cin_vc = 0; cin = 4'd2;
    tick(1);
    send = 2'b01; cin = 4'd3;
    tick(1);
    idle();
    chk("model_cnt0", cnt_m[0], 4);
    send = 2'b01;
    tick(3);
    chk("cnt0_3left", avail[0], 1);
    tick(1);
    chk("cnt0_empty", avail[0], 0);
    idle();
    cin_vld = 1; cin_vc = 0; cin = 4'd8;
    tick(1);
    idle();

    // VC1: 8 -> 7, return 3 saturates at 8.
    send = 2'b10;
    tick(1);
    idle();
    cin_vld = 1; cin_vc = 1; cin = 4'd3;
    tick(1);
    idle();
    chk("sat_err1", err[1], ERR_EN);
    chk("model_cnt1", cnt_m[1], 8);
    clr_err = 1;
    tick(1);
    clr_err = 0;
    chk("sat_clr", err, 0);
    send = 2'b10;
    tick(7);
    chk("sat_7sent", avail[1], 1);
    tick(1);
    chk("sat_8sent", avail[1], 0);
    idle();
    cin_vld = 1; cin_vc = 1; cin = 4'd8;
    tick(1);
    idle();

    // Pending returns on VC1 up to the force threshold.
    consumed = 2'b10;
    tick(5);
    chk("pend5_force", force_s, 0);
    tick(1);
    chk("pend6_force", force_s, 1);
    chk("pend6_vc", ts_vc, 1);
    chk("pend6_cnt", ts_cnt, 6);
    taken = 1;
    tick(1);
    chk("take_cons_cnt", ts_cnt, 1);
    chk("take_cons_force", force_s, 0);
    consumed = '0;
    tick(1);
    chk("take_empty", ts_vld, 0);
    taken = 0;

    // Tie 3/3 -> VC0 first, then VC1.
    consumed = 2'b11;
    tick(3);
    consumed = '0;
    chk("tie_vc", ts_vc, 0);
    chk("tie_cnt", ts_cnt, 3);
    taken = 1;
    tick(1);
    taken = 0;
    chk("tie_next_vc", ts_vc, 1);
    chk("tie_next_cnt", ts_cnt, 3);

    // Mixed traffic checked by the model only.
    for (int i = 0; i < 300; i++) begin
      send     = 2'($urandom_range(0, 3));
      cin_vld  = 1'($urandom_range(0, 1));
      cin_vc   = 1'($urandom_range(0, 1));
      cin      = 4'($urandom_range(0, 3));
      consumed = 2'($urandom_range(0, 3));
      taken    = 1'($urandom_range(0, 1));
      clr_err  = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    idle();

    // Asynchronous reset mid-stream.
    consumed = 2'b01; send = 2'b11;
    tick(2);
    idle();
    #2 rst_n = 0;
    #1;
    chk("arst_avail", avail, 3);
    chk("arst_vld", ts_vld, 0);
    chk("arst_force", force_s, 0);
    chk("arst_err", err, 0);
    @(negedge clk);
    rst_n = 1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
